// File: rtl/reg_dc_pipe.sv
// Register-decode stage: NREG-entry register file, two read ports with write-back bypass,
// 1-cycle latency into a one-entry valid/ready output register; stalled operands track write-back.
module reg_dc_pipe #(
  parameter int WIDTH     = 16,
  parameter int NREG      = 8,
  parameter int IDX_W     = 3,
  parameter int ZERO_REG0 = 0
) (
  input  logic             CLK_DC,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IDX_W-1:0] N_REG_A_IN,
  input  logic [IDX_W-1:0] N_REG_B_IN,
  input  logic             WB_EN,
  input  logic [IDX_W-1:0] N_REG_WB,
  input  logic [WIDTH-1:0] WB_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [IDX_W-1:0] N_REG_A_OUT,
  output logic [IDX_W-1:0] N_REG_B_OUT,
  output logic [WIDTH-1:0] REG_A_OUT,
  output logic [WIDTH-1:0] REG_B_OUT
);

  typedef struct packed {
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic [WIDTH-1:0] dat_a;
    logic [WIDTH-1:0] dat_b;
  } out_t;

  logic [WIDTH-1:0] regs [NREG];
  out_t             out_q;
  logic             out_vld;
  logic             accept;
  logic             consume;
  logic             wb_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign IN_READY = !out_vld || OUT_READY;
  assign accept   = IN_VALID && IN_READY;
  assign consume  = out_vld && OUT_READY;

  // Writes past the implemented file or into a hardwired zero register are dropped.
  assign wb_ok = WB_EN && (int'(N_REG_WB) < NREG) &&
                 !((ZERO_REG0 != 0) && (N_REG_WB == '0));

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int k = 0; k < NREG; k++) begin
      if (N_REG_A_IN == IDX_W'(k)) begin
        rd_a = (wb_ok && (N_REG_WB == IDX_W'(k))) ? WB_DATA : regs[k];
      end
      if (N_REG_B_IN == IDX_W'(k)) begin
        rd_b = (wb_ok && (N_REG_WB == IDX_W'(k))) ? WB_DATA : regs[k];
      end
    end
    if ((ZERO_REG0 != 0) && (N_REG_A_IN == '0)) rd_a = '0;
    if ((ZERO_REG0 != 0) && (N_REG_B_IN == '0)) rd_b = '0;
  end

  always_ff @(posedge CLK_DC) begin
    if (RST) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (wb_ok && (N_REG_WB == IDX_W'(k))) regs[k] <= WB_DATA;
      end
    end
  end

  always_ff @(posedge CLK_DC) begin
    if (RST) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (accept) begin
      out_vld     <= 1'b1;
      out_q.idx_a <= N_REG_A_IN;
      out_q.idx_b <= N_REG_B_IN;
      out_q.dat_a <= rd_a;
      out_q.dat_b <= rd_b;
    end else if (consume) begin
      out_vld <= 1'b0;
    end else if (out_vld) begin
      // Held operands follow write-back so they are current when finally consumed.
      if (wb_ok && (N_REG_WB == out_q.idx_a)) out_q.dat_a <= WB_DATA;
      if (wb_ok && (N_REG_WB == out_q.idx_b)) out_q.dat_b <= WB_DATA;
    end
  end

  assign OUT_VALID   = out_vld;
  assign N_REG_A_OUT = out_q.idx_a;
  assign N_REG_B_OUT = out_q.idx_b;
  assign REG_A_OUT   = out_q.dat_a;
  assign REG_B_OUT   = out_q.dat_b;

endmodule
